i2c_req_arbiter: RTL and testbench
==================================

// Module: i2c_req_arbiter
// PURPOSE
// - Round-robin arbiter sharing the i2c_master write FIFO among N_REQ requesters.
// - Each requester offers one {addr,data} write word via valid/ready.
// - Arbiter registers the winner into a one-word output stage and pushes it into the FIFO,
//   honouring fifo_full backpressure. Sits directly in front of i2c_master (data/addr/fifo_wr_en).
// PARAMETERS
// - N_REQ     4  number of requesters (2..8)
// - ADDR_W    7  I2C slave address width
// - DATA_W    8  data byte width
// - MAX_BURST 4  max consecutive grants to one locked requester (used only with I2C_ARB_LOCK_EN)
// PORTS
// - clk        in   1               system clock
// - arst       in   1               reset, synchronous, active-high
// - req_valid  in   N_REQ           per-requester word valid
// - req_addr   in   N_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
// - req_data   in   N_REQ*DATA_W    packed data bytes, requester i at [i*DATA_W +: DATA_W]
// - req_lock   in   N_REQ           burst-lock request (ignored without I2C_ARB_LOCK_EN)
// - req_ready  out  N_REQ           one-hot accept strobe, combinational
// - fifo_data  out  ADDR_W+DATA_W   {addr,data}; addr in MSBs [14:8] at defaults
// - fifo_wr_en out  1               FIFO write strobe, = out_valid & ~fifo_full
// - fifo_full  in   1               FIFO full from i2c_master
// - grant_id   out  $clog2(N_REQ)   source index of the word held in fifo_data
// - busy       out  1               out_valid | (|req_valid)
// BEHAVIOUR
// - Reset, synchronous on arst=1 at clk edge: out_valid=0, fifo_data=0, grant_id=0, ptr=0, burst_cnt=0.
//   req_ready and fifo_wr_en are forced 0 while arst=1. A held word is dropped on reset.
// - load_ok = ~out_valid | fifo_wr_en. Arbitration happens only when load_ok=1.
// - Winner w: first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N_REQ.
// - req_ready[w]=load_ok; all other bits are 0. At most one bit is high per cycle.
// - On accept (req_valid[w]&req_ready[w]) at edge t:
//   - fifo_data<={req_addr[w],req_data[w]}, grant_id<=w, out_valid<=1.
//   - ptr<=(w+1) mod N_REQ.
// - Latency: word accepted at edge t appears on fifo_data with fifo_wr_en=1 in cycle t+1
//   if fifo_full=0. Sustained throughput 1 word/clk.
// - out_valid<=0 when fifo_wr_en=1 and no new accept in the same cycle.
// - fifo_full=1: word held stable, fifo_wr_en=0, req_ready=0 for every requester, ptr frozen.
// - Same-cycle fifo_full deassert + pending requests: drain and reload in one cycle, no bubble.
// - No req_valid: out stage drains, ptr unchanged.
// - Requesters hold valid/addr/data until ready. Dropping valid early is a protocol violation.
//   The arbiter stays well-defined: it re-arbitrates next cycle.
// - ptr wraps N_REQ-1 -> 0. All-valid with ptr=N_REQ-1 grants N_REQ-1, then 0.
// CONFIGURATION
// - Macro I2C_ARB_LOCK_EN defined:
//   - On accept, if req_lock[w]=1 and burst_cnt<MAX_BURST-1: ptr<=w, burst_cnt<=burst_cnt+1.
//   - Otherwise ptr<=(w+1) mod N_REQ, burst_cnt<=0.
//   - burst_cnt also clears when the winner changes.
//   - Guarantees at most MAX_BURST consecutive grants to one requester, then rotation.
// - Undefined: req_lock is unused and burst_cnt is absent. Pure round-robin.
// STRUCTURE
// - Package i2c_arb_pkg:
//   - ADDR_W/DATA_W defaults, WORD_W=ADDR_W+DATA_W, IDX_W=$clog2(N_REQ) helper.
//   - Typedef i2c_word_t {addr,data}.
// - Sub-module rr_pick:
//   - Combinational rotate-by-ptr plus priority encode, then rotate back.
//   - Outputs one-hot grant, index and any_valid. Reusable by other arbiters.
// - Top holds the output register, ptr, burst_cnt and the handshake logic.
// TESTING
// - Reset: arst=1 for 2 clk with all req_valid=1.
//   -> req_ready=0, fifo_wr_en=0, fifo_data=0, grant_id=0.
//   After release, first grant goes to requester 0.
// - Round-robin: all 4 valid continuously, fifo_full=0.
//   -> grant_id sequence 0,1,2,3,0, one fifo_wr_en per clk.
//   Req 2 with addr=0x2A,data=0xC3 -> fifo_data=15'h2AC3.
// - Backpressure: fifo_full=1 for 5 clk while word {0x50,0x11} is held.
//   -> fifo_data stable, fifo_wr_en=0, req_ready=0.
//   On release the word writes the next clk and a new grant loads the same clk.
// - Sparse/wrap: only req 3 and req 1 valid, ptr=2.
//   -> grant 3, then 1 (wrap), then 3. Idle requesters never get ready.
// - Mid-op reset: arst pulsed while out_valid=1 and fifo_full=1.
//   -> word discarded, no fifo_wr_en for it, ptr=0.
// - With I2C_ARB_LOCK_EN, MAX_BURST=4: req 1 locked, all valid.
//   -> grants 1,1,1,1,2,3,0,1. Without the macro -> 1,2,3,0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared defaults and the {addr,data} write-word type for the i2c_master request arbiter.
package i2c_arb_pkg;

  localparam int ARB_N_REQ  = 4;
  localparam int ARB_ADDR_W = 7;
  localparam int ARB_DATA_W = 8;
  localparam int ARB_WORD_W = ARB_ADDR_W + ARB_DATA_W;

  // Index width for n requesters; a 1-requester build still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } i2c_word_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin pick: rotate requests by ptr, priority-encode, rotate the index back.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  localparam logic [IDX_W:0] N_V = (IDX_W+1)'(N);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    rot       = N'({req, req} >> ptr);
    any_valid = 1'b0;
    off       = '0;
    // Descending scan so the lowest rotated position (closest to ptr) wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_valid = 1'b1;
        off       = k[IDX_W-1:0];
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_V) sum = sum - N_V;
    idx   = sum[IDX_W-1:0];
    grant = '0;
    if (any_valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter feeding the i2c_master write FIFO through a one-word output stage.
// Optional burst lock of a requester is enabled by defining I2C_ARB_LOCK_EN.
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter  int N_REQ     = ARB_N_REQ,
  parameter  int ADDR_W    = ARB_ADDR_W,
  parameter  int DATA_W    = ARB_DATA_W,
  parameter  int MAX_BURST = 4,
  localparam int IDX_W     = idx_w(N_REQ),
  localparam int WORD_W    = ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ-1:0]         req_lock,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WORD_W-1:0]        fifo_data,
  output logic                     fifo_wr_en,
  input  logic                     fifo_full,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

  logic                vld_p1;
  logic [WORD_W-1:0]   word_p1;
  logic [IDX_W-1:0]    id_p1;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IDX_W-1:0]    ptr_inc;
  logic [N_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                load_ok;
  logic                accept;
  logic [WORD_W-1:0]   word_p0;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // The output stage can reload in the same cycle it drains, giving 1 word/clk.
  assign fifo_wr_en = vld_p1 & ~fifo_full & ~arst;
  assign load_ok    = ~vld_p1 | fifo_wr_en;
  assign accept     = load_ok & pick_any & ~arst;
  assign req_ready  = accept ? pick_grant : '0;
  assign busy       = vld_p1 | (|req_valid);
  assign fifo_data  = word_p1;
  assign grant_id   = id_p1;

  assign word_p0 = {req_addr[pick_idx*ADDR_W +: ADDR_W], req_data[pick_idx*DATA_W +: DATA_W]};
  assign ptr_inc = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;

`ifdef I2C_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST) + 1;

  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] cnt_eff;
  logic [BW-1:0] cnt_nxt;

  // A different winner than last time starts a fresh burst.
  assign cnt_eff = (pick_idx == id_p1) ? burst_cnt : '0;

  always_comb begin
    ptr_nxt = ptr_inc;
    cnt_nxt = '0;
    if (req_lock[pick_idx] && (cnt_eff < BW'(MAX_BURST - 1))) begin
      ptr_nxt = pick_idx;
      cnt_nxt = cnt_eff + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= cnt_nxt;
    end
  end
`else
  logic lock_unused;

  assign lock_unused = ^{req_lock, MAX_BURST[0]};
  assign ptr_nxt     = ptr_inc;
`endif

  // p0 -> p1: winner registered into the output stage
  always_ff @(posedge clk) begin
    if (arst) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
      id_p1   <= '0;
      ptr     <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      word_p1 <= word_p0;
      id_p1   <= pick_idx;
      ptr     <= ptr_nxt;
    end else if (fifo_wr_en) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed self-checking bench for i2c_req_arbiter (default build or I2C_ARB_LOCK_EN).
module tb_i2c_req_arbiter;
  import i2c_arb_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic [3:0]  req_valid;
  logic [27:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic [14:0] fifo_data;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter dut (
    .clk        (clk),
    .arst       (arst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_lock   (req_lock),
    .req_ready  (req_ready),
    .fifo_data  (fifo_data),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Requester i offers addr 0x28+i, data 0xC1+i (so requester 2 is {0x2A,0xC3}).
  function automatic logic [14:0] word_of(input int i);
    i2c_word_t w;
    w.addr = 7'(40 + i);
    w.data = 8'(193 + i);
    return w;
  endfunction

  task automatic set_words;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*7 +: 7] = 7'(40 + i);
      req_data[i*8 +: 8] = 8'(193 + i);
    end
  endtask

  task automatic do_reset;
    arst      = 1'b1;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    fifo_full = 1'b0;
    set_words();
    tick();
    tick();
  endtask

  task automatic test_reset;
    arst      = 1'b1;
    req_valid = 4'b1111;
    req_lock  = 4'b0000;
    fifo_full = 1'b0;
    set_words();
    settle();
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_ready_early got=%b want=%b", req_ready, 4'b0000);
    end
    tick();
    tick();
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_ready got=%b want=%b", req_ready, 4'b0000);
    end
    total++;
    if (fifo_wr_en !== 1'b0) begin
      bad++; $display("FAIL rst_wr_en got=%b want=0", fifo_wr_en);
    end
    total++;
    if (fifo_data !== 15'h0000) begin
      bad++; $display("FAIL rst_data got=%h want=0000", fifo_data);
    end
    total++;
    if (grant_id !== 2'd0) begin
      bad++; $display("FAIL rst_grant got=%0d want=0", grant_id);
    end
    arst = 1'b0;
    settle();
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL rst_first_ready got=%b want=%b", req_ready, 4'b0001);
    end
    tick();
    total++;
    if (grant_id !== 2'd0 || fifo_wr_en !== 1'b1) begin
      bad++; $display("FAIL rst_first_grant got=%0d/%b want=0/1", grant_id, fifo_wr_en);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    req_valid = 4'b1111;
    arst      = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick();
      total++;
      if (grant_id !== 2'(k % 4)) begin
        bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", k, grant_id, k % 4);
      end
      total++;
      if (fifo_wr_en !== 1'b1 || fifo_data !== word_of(k % 4)) begin
        bad++; $display("FAIL rr_word[%0d] got=%b/%h want=1/%h", k, fifo_wr_en, fifo_data, word_of(k % 4));
      end
      if (k == 2) begin
        total++;
        if (fifo_data !== 15'h2AC3) begin
          bad++; $display("FAIL rr_req2_word got=%h want=2ac3", fifo_data);
        end
      end
    end
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL rr_busy got=%b want=1", busy);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req_addr[6:0] = 7'h50;
    req_data[7:0] = 8'h11;
    req_valid     = 4'b0001;
    fifo_full     = 1'b1;
    arst          = 1'b0;
    settle();
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL bp_load_ready got=%b want=%b", req_ready, 4'b0001);
    end
    tick();
    req_valid = 4'b0010;
    settle();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (fifo_data !== 15'h5011 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h/%b/%b want=5011/0/0000", k, fifo_data, fifo_wr_en, req_ready);
      end
      tick();
    end
    fifo_full = 1'b0;
    settle();
    total++;
    if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_release got=%b/%b want=1/0010", fifo_wr_en, req_ready);
    end
    tick();
    total++;
    if (fifo_data !== 15'h29C2 || grant_id !== 2'd1 || fifo_wr_en !== 1'b1) begin
      bad++; $display("FAIL bp_reload got=%h/%0d/%b want=29c2/1/1", fifo_data, grant_id, fifo_wr_en);
    end
  endtask

  task automatic test_sparse_wrap;
    do_reset();
    req_valid = 4'b0010;
    arst      = 1'b0;
    tick();
    req_valid = 4'b1010;
    settle();
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL sw_ready0 got=%b want=1000", req_ready);
    end
    tick();
    total++;
    if (grant_id !== 2'd3) begin
      bad++; $display("FAIL sw_grant0 got=%0d want=3", grant_id);
    end
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL sw_ready1 got=%b want=0010", req_ready);
    end
    tick();
    total++;
    if (grant_id !== 2'd1) begin
      bad++; $display("FAIL sw_grant1 got=%0d want=1", grant_id);
    end
    total++;
    if (req_ready !== 4'b1000) begin
      bad++; $display("FAIL sw_ready2 got=%b want=1000", req_ready);
    end
    tick();
    total++;
    if (grant_id !== 2'd3 || fifo_data !== word_of(3)) begin
      bad++; $display("FAIL sw_grant2 got=%0d/%h want=3/%h", grant_id, fifo_data, word_of(3));
    end
  endtask

  task automatic test_midop_reset;
    do_reset();
    req_valid = 4'b0001;
    fifo_full = 1'b1;
    arst      = 1'b0;
    tick();
    req_valid = 4'b0000;
    settle();
    total++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL mr_held got=%b/%b want=0/1", fifo_wr_en, busy);
    end
    arst      = 1'b1;
    fifo_full = 1'b0;
    settle();
    total++;
    if (fifo_wr_en !== 1'b0) begin
      bad++; $display("FAIL mr_wr_in_rst got=%b want=0", fifo_wr_en);
    end
    tick();
    arst = 1'b0;
    settle();
    total++;
    if (fifo_wr_en !== 1'b0 || fifo_data !== 15'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL mr_dropped got=%b/%h/%b want=0/0000/0", fifo_wr_en, fifo_data, busy);
    end
    req_valid = 4'b1111;
    settle();
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL mr_ptr got=%b want=0001", req_ready);
    end
  endtask

  task automatic test_lock;
`ifdef I2C_ARB_LOCK_EN
    int exp_seq [8] = '{1, 1, 1, 1, 2, 3, 0, 1};
`else
    int exp_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
    do_reset();
    req_valid = 4'b0001;
    arst      = 1'b0;
    tick();
    req_valid = 4'b1111;
    req_lock  = 4'b0010;
    settle();
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (grant_id !== 2'(exp_seq[k])) begin
        bad++; $display("FAIL lock_grant[%0d] got=%0d want=%0d", k, grant_id, exp_seq[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_midop_reset();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
